// File: rtl/mpc_tx_sequencer_pkg.sv
// rtl/mpc_tx_sequencer_pkg.sv - shared state encoding and constants for the MPC transmit sequencer
// Contents: sequencer state enum, idle line byte, default blanking length.
package mpc_tx_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_RUN   = 2'd1,
        ST_TEST  = 2'd2
    } mpc_state_e;

    // Idle line is all ones; it matches what the DDR mux drives while its set input is high.
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    localparam int BLANK_CNT_DEFAULT = 16;

endpackage

// File: rtl/mpc_tx_sequencer_if.sv
// rtl/mpc_tx_sequencer_if.sv - signal bundle between trigger logic / VME regs and the MPC transmit sequencer
// Ports (slave = sequencer side):
//   in : lct_vld, lct_frame0, lct_frame1, mpc_tx_delay, mpc_enable, tp_mode, tp_trig, tp_nbx
//   out: mpc_din1st, mpc_din2nd, mpc_set, mpc_clock_en, tp_busy, mpc_sent, mpc_drop, mpc_sent_cnt
interface mpc_tx_sequencer_if #(
    parameter int MXFRAME = 32,
    parameter int MXDLY   = 4
);

    logic               lct_vld;
    logic [MXFRAME-1:0] lct_frame0;
    logic [MXFRAME-1:0] lct_frame1;
    logic [MXDLY-1:0]   mpc_tx_delay;
    logic               mpc_enable;
    logic               tp_mode;
    logic               tp_trig;
    logic [7:0]         tp_nbx;

    logic [MXFRAME-1:0] mpc_din1st;
    logic [MXFRAME-1:0] mpc_din2nd;
    logic               mpc_set;
    logic               mpc_clock_en;
    logic               tp_busy;
    logic               mpc_sent;
    logic               mpc_drop;
    logic [15:0]        mpc_sent_cnt;

    modport master (
        output lct_vld, lct_frame0, lct_frame1, mpc_tx_delay, mpc_enable,
               tp_mode, tp_trig, tp_nbx,
        input  mpc_din1st, mpc_din2nd, mpc_set, mpc_clock_en, tp_busy,
               mpc_sent, mpc_drop, mpc_sent_cnt
    );

    modport slave (
        input  lct_vld, lct_frame0, lct_frame1, mpc_tx_delay, mpc_enable,
               tp_mode, tp_trig, tp_nbx,
        output mpc_din1st, mpc_din2nd, mpc_set, mpc_clock_en, tp_busy,
               mpc_sent, mpc_drop, mpc_sent_cnt
    );

endinterface

// File: rtl/mpc_tx_sequencer_dly_srl.sv
// rtl/mpc_tx_sequencer_dly_srl.sv - 2**MXDLY deep {vld, data} shift register with variable read tap
// Ports:
//   clock    in  : bx clock
//   clear    in  : synchronous clear of every vld bit (data bits are don't-care when vld = 0)
//   din_vld  in  : valid bit shifted into stage 0
//   din      in  : payload shifted into stage 0
//   tap      in  : stage index to read
//   dout_vld out : vld bit of the selected stage
//   dout     out : payload of the selected stage
module mpc_tx_dly_srl #(
    parameter int WIDTH = 64,
    parameter int MXDLY = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    input  logic [MXDLY-1:0] tap,
    output logic             dout_vld,
    output logic [WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** MXDLY;

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], din_vld};
        end
        data_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign dout_vld = vld_q[tap];
    assign dout     = data_q[tap];

endmodule

// File: rtl/mpc_tx_sequencer.sv
// rtl/mpc_tx_sequencer.sv - delays per-bx LCT frame pairs and sequences blanking / test bursts into the MPC DDR mux
// Ports:
//   clock in : 40 MHz bx clock
//   reset in : synchronous, active-high
//   bus       : mpc_tx_sequencer_if.slave (frame inputs, delay/enable/test controls, mux outputs and status)
module mpc_tx_sequencer
    import mpc_tx_sequencer_pkg::*;
#(
    parameter int MXFRAME   = 32,
    parameter int MXDLY     = 4,
    parameter int BLANK_CNT = BLANK_CNT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    mpc_tx_sequencer_if.slave bus
);

    localparam int                 NBYTE     = MXFRAME / 8;
    localparam int                 BW        = $clog2(BLANK_CNT + 1);
    localparam logic [MXFRAME-1:0] IDLE      = {NBYTE{IDLE_BYTE}};
    localparam logic [BW-1:0]      BLANK_MAX = BW'(BLANK_CNT);

    mpc_state_e         state_q;
    logic [BW-1:0]      blank_cnt_q;
    logic [7:0]         pat_q;
    logic [7:0]         bx_left_q;

    logic               in_vld_q;
    logic [MXFRAME-1:0] in_f0_q;
    logic [MXFRAME-1:0] in_f1_q;

    logic [MXFRAME-1:0] din1st_q;
    logic [MXFRAME-1:0] din2nd_q;
    logic               set_q;
    logic               clock_en_q;
    logic               busy_q;
    logic               sent_q;
    logic               drop_q;
    logic [15:0]        sent_cnt_q;

    logic                 tap_vld;
    logic [2*MXFRAME-1:0] tap_data;
    logic [MXFRAME-1:0]   tap_f0;
    logic [MXFRAME-1:0]   tap_f1;
    logic [15:0]          sent_cnt_inc;
    logic                 srl_clear;

    // The delay line is held empty throughout BLANK so stale frames never leak into RUN.
    assign srl_clear = reset || (state_q == ST_BLANK);

    mpc_tx_dly_srl #(
        .WIDTH (2 * MXFRAME),
        .MXDLY (MXDLY)
    ) u_dly (
        .clock    (clock),
        .clear    (srl_clear),
        .din_vld  (in_vld_q),
        .din      ({in_f0_q, in_f1_q}),
        .tap      (bus.mpc_tx_delay),
        .dout_vld (tap_vld),
        .dout     (tap_data)
    );

    always_comb begin
        tap_f0       = IDLE;
        tap_f1       = IDLE;
        sent_cnt_inc = (sent_cnt_q == 16'hFFFF) ? sent_cnt_q : sent_cnt_q + 16'd1;
        if (tap_vld) begin
            tap_f0 = tap_data[2*MXFRAME-1:MXFRAME];
            tap_f1 = tap_data[MXFRAME-1:0];
        end
    end

    // Outputs are registered against the state being entered, so mpc_set drops on the
    // first RUN clock and rises on the first BLANK clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_BLANK;
            blank_cnt_q <= '0;
            pat_q       <= '0;
            bx_left_q   <= '0;
            in_vld_q    <= 1'b0;
            in_f0_q     <= IDLE;
            in_f1_q     <= IDLE;
            din1st_q    <= IDLE;
            din2nd_q    <= IDLE;
            set_q       <= 1'b1;
            clock_en_q  <= 1'b1;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            drop_q      <= 1'b0;
            sent_cnt_q  <= '0;
        end else begin
            clock_en_q <= 1'b1;
            // Frames arriving during a test burst are discarded and flagged.
            in_vld_q   <= bus.lct_vld && (state_q != ST_TEST);
            drop_q     <= bus.lct_vld && (state_q == ST_TEST);
            in_f0_q    <= bus.lct_frame0;
            in_f1_q    <= bus.lct_frame1;

            case (state_q)
                ST_BLANK: begin
                    din1st_q <= IDLE;
                    din2nd_q <= IDLE;
                    sent_q   <= 1'b0;
                    busy_q   <= 1'b0;
                    if (blank_cnt_q != BLANK_MAX) begin
                        blank_cnt_q <= blank_cnt_q + BW'(1);
                    end
                    if ((blank_cnt_q == BLANK_MAX) && bus.mpc_enable) begin
                        state_q <= ST_RUN;
                        set_q   <= 1'b0;
                    end else begin
                        set_q   <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (!bus.mpc_enable) begin
                        state_q     <= ST_BLANK;
                        blank_cnt_q <= '0;
                        din1st_q    <= IDLE;
                        din2nd_q    <= IDLE;
                        set_q       <= 1'b1;
                        sent_q      <= 1'b0;
                    end else if (bus.tp_mode && bus.tp_trig) begin
                        // First pattern (0) goes out on the trigger clock; tp_nbx = 0
                        // wraps to 255 remaining, giving a 256 bx burst.
                        state_q    <= ST_TEST;
                        busy_q     <= 1'b1;
                        pat_q      <= 8'd1;
                        bx_left_q  <= bus.tp_nbx - 8'd1;
                        din1st_q   <= '0;
                        din2nd_q   <= '1;
                        sent_q     <= 1'b1;
                        sent_cnt_q <= sent_cnt_inc;
                    end else begin
                        din1st_q   <= tap_f0;
                        din2nd_q   <= tap_f1;
                        sent_q     <= tap_vld;
                        if (tap_vld) begin
                            sent_cnt_q <= sent_cnt_inc;
                        end
                    end
                end

                ST_TEST: begin
                    if (!bus.mpc_enable) begin
                        state_q     <= ST_BLANK;
                        blank_cnt_q <= '0;
                        busy_q      <= 1'b0;
                        din1st_q    <= IDLE;
                        din2nd_q    <= IDLE;
                        set_q       <= 1'b1;
                        sent_q      <= 1'b0;
                    end else if (bx_left_q == 8'd0) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b0;
                        din1st_q <= tap_f0;
                        din2nd_q <= tap_f1;
                        sent_q   <= tap_vld;
                        if (tap_vld) begin
                            sent_cnt_q <= sent_cnt_inc;
                        end
                    end else begin
                        din1st_q   <= {NBYTE{pat_q}};
                        din2nd_q   <= ~{NBYTE{pat_q}};
                        pat_q      <= pat_q + 8'd1;
                        bx_left_q  <= bx_left_q - 8'd1;
                        sent_q     <= 1'b1;
                        sent_cnt_q <= sent_cnt_inc;
                    end
                end

                default: begin
                    state_q     <= ST_BLANK;
                    blank_cnt_q <= '0;
                    busy_q      <= 1'b0;
                    din1st_q    <= IDLE;
                    din2nd_q    <= IDLE;
                    set_q       <= 1'b1;
                    sent_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mpc_din1st   = din1st_q;
    assign bus.mpc_din2nd   = din2nd_q;
    assign bus.mpc_set      = set_q;
    assign bus.mpc_clock_en = clock_en_q;
    assign bus.tp_busy      = busy_q;
    assign bus.mpc_sent     = sent_q;
    assign bus.mpc_drop     = drop_q;
    assign bus.mpc_sent_cnt = sent_cnt_q;

endmodule
